// File: rtl/mouse_action_ctrl.sv
// mouse_action_ctrl: turns mouse clicks and cheat gestures into board
// commands and merges them with remote commands onto one valid/ready slot.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                clears selection and local pending command
//   my_turn_i              local player may act
//   l_click_i              single-cycle left-click pulse
//   cheat_activate_i       single-cycle cheat-gesture pulse
//   mouse_inblock_i        cursor is over a board block
//   mouse_block_x_i/_y_i   block column (0-17) / row (0-7)
//   remote_req_i/_cmd_i    remote command, held until remote_ack_o
//   remote_ack_o           one-cycle pulse: remote command accepted
//   cmd_valid_o/cmd_o      output command {kind,src_x,src_y,dst_x,dst_y}
//   cmd_remote_o           current cmd_o came from remote
//   cmd_ready_i            consumer accepts cmd_o
//   sel_active_o/_x_o/_y_o held source selection
module mouse_action_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic        my_turn_i,
   input  logic        l_click_i,
   input  logic        cheat_activate_i,
   input  logic        mouse_inblock_i,
   input  logic [4:0]  mouse_block_x_i,
   input  logic [2:0]  mouse_block_y_i,
   input  logic        remote_req_i,
   input  logic [17:0] remote_cmd_i,
   output logic        remote_ack_o,
   output logic        cmd_valid_o,
   output logic [17:0] cmd_o,
   output logic        cmd_remote_o,
   input  logic        cmd_ready_i,
   output logic        sel_active_o,
   output logic [4:0]  sel_x_o,
   output logic [2:0]  sel_y_o
);

   localparam int unsigned CNT_W = 27;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [1:0] KIND_MOVE  = 2'b01;
   localparam logic [1:0] KIND_CHEAT = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HELD,
      ST_WAIT
   } state_e;

   state_e      state_q, state_d;
   logic [17:0] pend_q, pend_d;
   logic        pend_full_q, pend_full_d;
   logic [4:0]  sel_x_q, sel_x_d;
   logic [2:0]  sel_y_q, sel_y_d;
   logic        sel_active_q, sel_active_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [17:0] cmd_q, cmd_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic        cmd_remote_q, cmd_remote_d;
   logic        remote_ack_q, remote_ack_d;
   logic        last_rem_q, last_rem_d;

   logic click_ok;
   logic same_blk;
   logic timed_out;
   logic slot_free;
   logic rem_cand;
   logic loc_cand;
   logic gnt_rem;
   logic gnt_loc;

   // Every 3-bit row value is a legal row, so only the column is range-checked.
   assign click_ok  = l_click_i && my_turn_i && mouse_inblock_i &&
                      (mouse_block_x_i <= 5'd17);
   assign same_blk  = (mouse_block_x_i == sel_x_q) &&
                      (mouse_block_y_i == sel_y_q);
   assign timed_out = (cnt_q == CNT_LAST);

   // The remote side keeps its request up through the ack cycle, so the
   // request is ignored while our own ack is still visible.
   assign slot_free = !cmd_valid_q || cmd_ready_i;
   assign rem_cand  = remote_req_i && !remote_ack_q;
   assign loc_cand  = pend_full_q;
   assign gnt_rem   = slot_free && rem_cand && (!loc_cand || !last_rem_q);
   assign gnt_loc   = slot_free && loc_cand && (!rem_cand || last_rem_q);

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      sel_x_d     = sel_x_q;
      sel_y_d     = sel_y_q;
      cnt_d       = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cheat_activate_i) begin
               state_d     = ST_WAIT;
               pend_d      = {KIND_CHEAT, 16'b0};
               pend_full_d = 1'b1;
            end else if (click_ok) begin
               state_d = ST_HELD;
               sel_x_d = mouse_block_x_i;
               sel_y_d = mouse_block_y_i;
               cnt_d   = '0;
            end
         end
         ST_HELD: begin
            if (cheat_activate_i) begin
               state_d     = ST_WAIT;
               pend_d      = {KIND_CHEAT, 16'b0};
               pend_full_d = 1'b1;
            end else if (!my_turn_i) begin
               state_d = ST_IDLE;
            end else if (l_click_i) begin
               if (click_ok && !same_blk) begin
                  state_d     = ST_WAIT;
                  pend_d      = {KIND_MOVE, sel_x_q, sel_y_q,
                                 mouse_block_x_i, mouse_block_y_i};
                  pend_full_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (timed_out) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (gnt_loc) begin
               state_d     = ST_IDLE;
               pend_full_d = 1'b0;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            pend_full_d = 1'b0;
         end
      endcase
      if (flush_i) begin
         state_d     = ST_IDLE;
         pend_d      = '0;
         pend_full_d = 1'b0;
         cnt_d       = '0;
      end
   end

   assign sel_active_d = (state_d == ST_HELD);

   always_comb begin
      cmd_d        = cmd_q;
      cmd_valid_d  = cmd_valid_q && !cmd_ready_i;
      cmd_remote_d = cmd_remote_q;
      last_rem_d   = last_rem_q;
      remote_ack_d = gnt_rem;
      unique case (1'b1)
         gnt_rem: begin
            cmd_d        = remote_cmd_i;
            cmd_valid_d  = 1'b1;
            cmd_remote_d = 1'b1;
            last_rem_d   = 1'b1;
         end
         gnt_loc: begin
            cmd_d        = pend_q;
            cmd_valid_d  = 1'b1;
            cmd_remote_d = 1'b0;
            last_rem_d   = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         pend_q       <= '0;
         pend_full_q  <= 1'b0;
         sel_x_q      <= '0;
         sel_y_q      <= '0;
         sel_active_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         pend_full_q  <= pend_full_d;
         sel_x_q      <= sel_x_d;
         sel_y_q      <= sel_y_d;
         sel_active_q <= sel_active_d;
         cnt_q        <= cnt_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cmd_q        <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_remote_q <= 1'b0;
         remote_ack_q <= 1'b0;
         last_rem_q   <= 1'b0;
      end else begin
         cmd_q        <= cmd_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_remote_q <= cmd_remote_d;
         remote_ack_q <= remote_ack_d;
         last_rem_q   <= last_rem_d;
      end
   end

   assign remote_ack_o = remote_ack_q;
   assign cmd_valid_o  = cmd_valid_q;
   assign cmd_o        = cmd_q;
   assign cmd_remote_o = cmd_remote_q;
   assign sel_active_o = sel_active_q;
   assign sel_x_o      = sel_x_q;
   assign sel_y_o      = sel_y_q;

endmodule

// File: tb/tb_mouse_action_ctrl.sv
// tb_mouse_action_ctrl: directed vector table plus hand-written sequences
// for mouse_action_ctrl with a 16-cycle selection timeout.
module tb_mouse_action_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush, my_turn, l_click, cheat, inb;
   logic [4:0]  bx;
   logic [2:0]  by;
   logic        rreq;
   logic [17:0] rcmd;
   logic        rack;
   logic        cvalid;
   logic [17:0] cmd;
   logic        crem;
   logic        crdy;
   logic        sel;
   logic [4:0]  sx;
   logic [2:0]  sy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mouse_action_ctrl #(.TIMEOUT_CYC(16)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .flush_i          (flush),
      .my_turn_i        (my_turn),
      .l_click_i        (l_click),
      .cheat_activate_i (cheat),
      .mouse_inblock_i  (inb),
      .mouse_block_x_i  (bx),
      .mouse_block_y_i  (by),
      .remote_req_i     (rreq),
      .remote_cmd_i     (rcmd),
      .remote_ack_o     (rack),
      .cmd_valid_o      (cvalid),
      .cmd_o            (cmd),
      .cmd_remote_o     (crem),
      .cmd_ready_i      (crdy),
      .sel_active_o     (sel),
      .sel_x_o          (sx),
      .sel_y_o          (sy)
   );

   // fi = {flush,turn,click,cheat,inblock,rreq,ready}
   // fo = {valid,remote,ack,sel}
   typedef struct {
      string       name;
      logic [6:0]  fi;
      logic [4:0]  x;
      logic [2:0]  y;
      logic [17:0] rc;
      logic [3:0]  fo;
      logic [17:0] ec;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, act, exp);
      end
   endtask

   task automatic add(input string n, input logic [6:0] fi,
                      input logic [4:0] x, input logic [2:0] y,
                      input logic [17:0] rc, input logic [3:0] fo,
                      input logic [17:0] ec);
      vec_t v;
      v.name = n;
      v.fi   = fi;
      v.x    = x;
      v.y    = y;
      v.rc   = rc;
      v.fo   = fo;
      v.ec   = ec;
      tbl.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      l_click = 1'b0;
      cheat   = 1'b0;
      flush   = 1'b0;
   endtask

   task automatic click(input logic [4:0] x, input logic [2:0] y);
      l_click = 1'b1;
      inb     = 1'b1;
      bx      = x;
      by      = y;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      flush   = 1'b0;
      my_turn = 1'b0;
      l_click = 1'b0;
      cheat   = 1'b0;
      inb     = 1'b0;
      bx      = '0;
      by      = '0;
      rreq    = 1'b0;
      rcmd    = '0;
      crdy    = 1'b0;

      add("idle",  7'b0100001, 5'd0,  3'd0, 18'h0, 4'b0000, 18'h0);
      add("c1",    7'b0110101, 5'd3,  3'd2, 18'h0, 4'b0001, 18'h0);
      add("hold",  7'b0100001, 5'd0,  3'd0, 18'h0, 4'b0001, 18'h0);
      add("c2",    7'b0110101, 5'd7,  3'd5, 18'h0, 4'b0000, 18'h0);
      add("mv",    7'b0100001, 5'd0,  3'd0, 18'h0, 4'b1000,
          {2'b01, 5'd3, 3'd2, 5'd7, 3'd5});
      add("mv_end",7'b0100001, 5'd0,  3'd0, 18'h0, 4'b0000, 18'h0);
      add("s44a",  7'b0110101, 5'd4,  3'd4, 18'h0, 4'b0001, 18'h0);
      add("s44b",  7'b0110101, 5'd4,  3'd4, 18'h0, 4'b0000, 18'h0);
      add("s44n",  7'b0100001, 5'd0,  3'd0, 18'h0, 4'b0000, 18'h0);
      add("t44a",  7'b0110101, 5'd4,  3'd4, 18'h0, 4'b0001, 18'h0);
      add("badx",  7'b0110101, 5'd18, 3'd4, 18'h0, 4'b0000, 18'h0);
      add("badx_n",7'b0100001, 5'd0,  3'd0, 18'h0, 4'b0000, 18'h0);
      add("u44a",  7'b0110101, 5'd4,  3'd4, 18'h0, 4'b0001, 18'h0);
      add("outb",  7'b0110001, 5'd4,  3'd4, 18'h0, 4'b0000, 18'h0);
      add("outb_n",7'b0100001, 5'd0,  3'd0, 18'h0, 4'b0000, 18'h0);
      add("h56",   7'b0110101, 5'd5,  3'd6, 18'h0, 4'b0001, 18'h0);
      add("cht",   7'b0111101, 5'd6,  3'd6, 18'h0, 4'b0000, 18'h0);
      add("cht_o", 7'b0100001, 5'd0,  3'd0, 18'h0, 4'b1000, 18'h20000);
      add("cht_e", 7'b0100001, 5'd0,  3'd0, 18'h0, 4'b0000, 18'h0);
      add("t00",   7'b0110101, 5'd0,  3'd0, 18'h0, 4'b0001, 18'h0);
      add("noturn",7'b0000001, 5'd0,  3'd0, 18'h0, 4'b0000, 18'h0);
      add("nt_clk",7'b0010101, 5'd1,  3'd1, 18'h0, 4'b0000, 18'h0);
      add("b177",  7'b0110101, 5'd17, 3'd7, 18'h0, 4'b0001, 18'h0);
      add("b00",   7'b0110101, 5'd0,  3'd0, 18'h0, 4'b0000, 18'h0);
      add("b_mv",  7'b0100001, 5'd0,  3'd0, 18'h0, 4'b1000,
          {2'b01, 5'd17, 3'd7, 5'd0, 3'd0});
      add("r1",    7'b0100011, 5'd0,  3'd0, 18'h2ABCD, 4'b1110, 18'h2ABCD);
      add("r1e",   7'b0100001, 5'd0,  3'd0, 18'h0, 4'b0000, 18'h0);
      add("B1",    7'b0110100, 5'd3,  3'd3, 18'h0, 4'b0001, 18'h0);
      add("B2",    7'b0110110, 5'd6,  3'd1, 18'h2ABCD, 4'b1110, 18'h2ABCD);
      add("B3",    7'b0100000, 5'd0,  3'd0, 18'h0, 4'b1100, 18'h2ABCD);
      add("B4",    7'b0100010, 5'd0,  3'd0, 18'h01234, 4'b1100, 18'h2ABCD);
      add("B5",    7'b0100011, 5'd0,  3'd0, 18'h01234, 4'b1000,
          {2'b01, 5'd3, 3'd3, 5'd6, 3'd1});
      add("B6",    7'b0100011, 5'd0,  3'd0, 18'h01234, 4'b1110, 18'h01234);
      add("B7",    7'b0100001, 5'd0,  3'd0, 18'h0, 4'b0000, 18'h0);

      repeat (2) @(posedge clk);
      #1;
      chk("rst.valid", 32'(cvalid), 32'd0);
      chk("rst.ack",   32'(rack),   32'd0);
      chk("rst.cmd",   32'(cmd),    32'd0);
      chk("rst.rem",   32'(crem),   32'd0);
      chk("rst.sel",   32'(sel),    32'd0);
      chk("rst.sx",    32'(sx),     32'd0);
      chk("rst.sy",    32'(sy),     32'd0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         {flush, my_turn, l_click, cheat, inb, rreq, crdy} = tbl[i].fi;
         bx   = tbl[i].x;
         by   = tbl[i].y;
         rcmd = tbl[i].rc;
         @(posedge clk);
         #1;
         chk({tbl[i].name, ".valid"}, 32'(cvalid), 32'(tbl[i].fo[3]));
         chk({tbl[i].name, ".ack"},   32'(rack),   32'(tbl[i].fo[1]));
         chk({tbl[i].name, ".sel"},   32'(sel),    32'(tbl[i].fo[0]));
         if (tbl[i].fo[3]) begin
            chk({tbl[i].name, ".cmd"}, 32'(cmd),  32'(tbl[i].ec));
            chk({tbl[i].name, ".rem"}, 32'(crem), 32'(tbl[i].fo[2]));
         end
      end
      {flush, my_turn, l_click, cheat, inb, rreq, crdy} = 7'b0100001;

      // alternation with remote held continuously
      cheat = 1'b1;
      tick();
      chk("alt.c1.valid", 32'(cvalid), 32'd0);
      tick();
      chk("alt.c1.cmd",   32'(cmd),    32'h20000);
      chk("alt.c1.rem",   32'(crem),   32'd0);
      cheat = 1'b1;
      tick();
      chk("alt.c2.valid", 32'(cvalid), 32'd0);
      rreq = 1'b1;
      rcmd = 18'h15555;
      tick();
      chk("alt.g1.ack",   32'(rack),   32'd1);
      chk("alt.g1.rem",   32'(crem),   32'd1);
      chk("alt.g1.cmd",   32'(cmd),    32'h15555);
      tick();
      chk("alt.g2.ack",   32'(rack),   32'd0);
      chk("alt.g2.valid", 32'(cvalid), 32'd1);
      chk("alt.g2.rem",   32'(crem),   32'd0);
      chk("alt.g2.cmd",   32'(cmd),    32'h20000);
      tick();
      chk("alt.g3.ack",   32'(rack),   32'd1);
      chk("alt.g3.rem",   32'(crem),   32'd1);
      tick();
      chk("alt.g4.valid", 32'(cvalid), 32'd0);
      chk("alt.g4.ack",   32'(rack),   32'd0);
      rreq = 1'b0;
      tick();
      chk("alt.end.valid", 32'(cvalid), 32'd0);

      // selection timeout
      click(5'd1, 3'd1);
      tick();
      chk("to.start", 32'(sel), 32'd1);
      repeat (14) tick();
      tick();
      chk("to.e15", 32'(sel), 32'd1);
      tick();
      chk("to.e16", 32'(sel), 32'd0);
      click(5'd2, 3'd2);
      tick();
      chk("to.new.sel",   32'(sel),    32'd1);
      chk("to.new.valid", 32'(cvalid), 32'd0);
      tick();
      chk("to.new2.sel",   32'(sel),    32'd1);
      chk("to.new2.valid", 32'(cvalid), 32'd0);
      click(5'd2, 3'd2);
      tick();
      chk("to.desel", 32'(sel), 32'd0);

      // flush while the local command waits behind a stalled slot
      crdy = 1'b0;
      rreq = 1'b1;
      rcmd = 18'h0AAAA;
      click(5'd1, 3'd2);
      tick();
      chk("fl.ack", 32'(rack), 32'd1);
      chk("fl.sel", 32'(sel),  32'd1);
      chk("fl.sx",  32'(sx),   32'd1);
      chk("fl.sy",  32'(sy),   32'd2);
      rreq = 1'b0;
      click(5'd5, 3'd2);
      tick();
      chk("fl.wait.sel", 32'(sel), 32'd0);
      chk("fl.wait.cmd", 32'(cmd), 32'h0AAAA);
      flush = 1'b1;
      tick();
      chk("fl.hold.valid", 32'(cvalid), 32'd1);
      chk("fl.hold.cmd",   32'(cmd),    32'h0AAAA);
      crdy = 1'b1;
      tick();
      chk("fl.drain", 32'(cvalid), 32'd0);
      tick();
      chk("fl.none", 32'(cvalid), 32'd0);

      // reset in the middle of a handshake
      crdy = 1'b0;
      rreq = 1'b1;
      rcmd = 18'h3FFFF;
      tick();
      chk("mr.valid", 32'(cvalid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr.rst.valid", 32'(cvalid), 32'd0);
      chk("mr.rst.ack",   32'(rack),   32'd0);
      chk("mr.rst.cmd",   32'(cmd),    32'd0);
      chk("mr.rst.rem",   32'(crem),   32'd0);
      rreq = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("mr.after", 32'(cvalid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
